// File: rtl/texture_cache_fill_pkg.sv
// rtl/texture_cache_fill_pkg.sv - shared address widths and refill FSM encoding
package texture_cache_fill_pkg;

  localparam int ENTRY_W = 17;
  localparam int HALF_W  = 19;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_REQ_ENC    = 3'd1;
  localparam logic [2:0] ST_BEAT0_ENC  = 3'd2;
  localparam logic [2:0] ST_BEAT1_ENC  = 3'd3;
  localparam logic [2:0] ST_WRITE_ENC  = 3'd4;
  localparam logic [2:0] ST_SETTLE_ENC = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_REQ    = ST_REQ_ENC,
    ST_BEAT0  = ST_BEAT0_ENC,
    ST_BEAT1  = ST_BEAT1_ENC,
    ST_WRITE  = ST_WRITE_ENC,
    ST_SETTLE = ST_SETTLE_ENC
  } fillState_t;

  // A cache entry holds four halfwords, so the entry index drops the low two bits.
  function automatic logic [ENTRY_W-1:0] entryOf(input logic [HALF_W-1:0] halfAddr);
    return halfAddr[HALF_W-1:2];
  endfunction

endpackage

// File: rtl/texture_cache_fill.sv
// rtl/texture_cache_fill.sv - texture cache miss refill: round-robin A/B, two-beat VRAM read, one atomic 64-bit write
module texture_cache_fill
  import texture_cache_fill_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  logic                i_missA,
  input  logic [HALF_W-1:0]   i_adressLookA,
  input  logic                i_missB,
  input  logic [HALF_W-1:0]   i_adressLookB,
  output logic                o_memRequest,
  output logic [ENTRY_W-1:0]  o_memAdress,
  input  logic                i_memAck,
  input  logic                i_memDataValid,
  input  logic [31:0]         i_memData,
  output logic                o_cacheWrite,
  output logic [ENTRY_W-1:0]  o_cacheAdress,
  output logic [63:0]         o_cacheData,
  output logic                o_busy
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

  fillState_t          state;
  fillState_t          stateNext;
  logic                lastB;
  logic                selB;
  logic                anyMiss;
  logic [ENTRY_W-1:0]  selAddr;
  logic [63:0]         assembly;
  logic [CNT_W-1:0]    settleCnt;
  logic                unusedLowBits;

  assign unusedLowBits = ^{i_adressLookA[1:0], i_adressLookB[1:0]};

  // On a tie the port not served last wins; a dual match still flips the pointer.
  always_comb begin
    anyMiss   = i_missA | i_missB;
    selB      = i_missB & (~i_missA | ~lastB);
    selAddr   = selB ? entryOf(i_adressLookB) : entryOf(i_adressLookA);
    stateNext = state;
    case (state)
      ST_IDLE:   if (anyMiss)               stateNext = ST_REQ;
      ST_REQ:    if (i_memAck)              stateNext = ST_BEAT0;
      ST_BEAT0:  if (i_memDataValid)        stateNext = ST_BEAT1;
      ST_BEAT1:  if (i_memDataValid)        stateNext = ST_WRITE;
      ST_WRITE:                             stateNext = ST_SETTLE;
      ST_SETTLE: if (settleCnt == SETTLE_LAST) stateNext = ST_IDLE;
      default:                              stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state         <= ST_IDLE;
      lastB         <= 1'b1;
      settleCnt     <= '0;
      assembly      <= '0;
      o_memRequest  <= 1'b0;
      o_memAdress   <= '0;
      o_cacheWrite  <= 1'b0;
      o_cacheAdress <= '0;
      o_cacheData   <= '0;
      o_busy        <= 1'b0;
    end else begin
      state        <= stateNext;
      o_memRequest <= (stateNext == ST_REQ);
      o_busy       <= (stateNext != ST_IDLE);
      o_cacheWrite <= (state == ST_WRITE);

      if (state == ST_IDLE && anyMiss) begin
        o_memAdress <= selAddr;
        lastB       <= selB;
      end

      if (state == ST_BEAT0 && i_memDataValid) assembly[31:0]  <= i_memData;
      if (state == ST_BEAT1 && i_memDataValid) assembly[63:32] <= i_memData;

      if (state == ST_WRITE) begin
        o_cacheAdress <= o_memAdress;
        o_cacheData   <= assembly;
      end

      // SETTLE spans the write-strobe cycle plus SETTLE_CYCLES quiet cycles.
      if (state == ST_SETTLE && settleCnt != SETTLE_LAST)
        settleCnt <= settleCnt + CNT_W'(1);
      else
        settleCnt <= '0;
    end
  end

endmodule
